// File: rtl/tqvp_fir_pkg.sv
// TinyQV FIR MAC filter: shared definitions.
// Register addresses, CTRL fields and sequencer states.
package tqvp_fir_pkg;

    localparam logic [3:0] ADDR_OUT       = 4'h0;
    localparam logic [3:0] ADDR_STATUS    = 4'h1;
    localparam logic [3:0] ADDR_CTRL      = 4'h2;
    localparam logic [3:0] ADDR_COUNT     = 4'h3;
    localparam logic [3:0] ADDR_COEF_BASE = 4'h4;

    localparam int CTRL_SRC      = 0;
    localparam int CTRL_SHIFT_LO = 1;
    localparam int CTRL_SHIFT_HI = 3;
    localparam int CTRL_CLR      = 7;

    localparam int STATUS_OVR_CLR = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_DONE
    } fir_state_e;

endpackage

// File: rtl/tqvp_fir_mac_unit.sv
// TinyQV FIR MAC filter: one-tap-per-cycle multiply-accumulate.
// Sequences taps, then scales and saturates the sum to 8 bits.
module tqvp_fir_mac_unit
    import tqvp_fir_pkg::*;
#(
    parameter int TAPS  = 8,
    parameter int ACC_W = 16 + $clog2(TAPS),
    parameter int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       shift,
    input  logic [7:0]       sample,
    input  logic [7:0]       coef,
    output logic [IDX_W-1:0] tap_sel,
    output logic             busy,
    output logic             done,
    output logic [7:0]       result
);

    fir_state_e       state_q;
    fir_state_e       state_d;
    logic [ACC_W-1:0] acc_q;
    logic [IDX_W-1:0] idx_q;
    logic [15:0]      product;
    logic [ACC_W-1:0] scaled;
    logic             last_tap;

    assign product  = {8'h00, sample} * {8'h00, coef};
    assign last_tap = (idx_q == IDX_W'(TAPS - 1));
    assign scaled   = acc_q >> shift;
    assign result   = (scaled > ACC_W'(255)) ? 8'hff : scaled[7:0];
    assign tap_sel  = idx_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

    // State register; abort and reset both land in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: IDLE -> MAC for TAPS cycles -> DONE for one cycle.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (start) state_d = ST_MAC;
                ST_MAC:  if (last_tap) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Accumulator and tap index; cleared on entry to MAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            idx_q <= '0;
        end else if (abort || (state_q == ST_IDLE && start)) begin
            acc_q <= '0;
            idx_q <= '0;
        end else if (state_q == ST_MAC) begin
            acc_q <= acc_q + ACC_W'(product);
            idx_q <= idx_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/tqvp_fir_mac_filter.sv
// TinyQV FIR MAC filter peripheral: registers, delay line, bus.
// Programmable-coefficient FIR with shift/saturate output.
module tqvp_fir_mac_filter
    import tqvp_fir_pkg::*;
#(
    parameter int TAPS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [3:0] address,
    input  logic       data_write,
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam int ACC_W = 16 + $clog2(TAPS);
    localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;

    logic [7:0]       samples_q [TAPS];
    logic [7:0]       coef_q    [TAPS];
    logic [7:0]       out_q;
    logic             src_q;
    logic [2:0]       shift_q;
    logic [3:0]       count_q;
    logic             ovr_q;
    logic             valid_q;

    logic             busy;
    logic             done;
    logic [7:0]       result;
    logic [IDX_W-1:0] tap_sel;
    logic [7:0]       cur_sample;
    logic [7:0]       cur_coef;

    logic             wr_push;
    logic             wr_status;
    logic             wr_ctrl;
    logic             wr_coef;
    logic             is_coef;
    logic             clr;
    logic             push_ok;
    logic [3:0]       coef_idx;
    logic [4:0]       addr_ext;
    logic [7:0]       new_sample;

    assign addr_ext   = {1'b0, address};
    assign is_coef    = (addr_ext >= 5'(ADDR_COEF_BASE)) &&
                        (addr_ext < 5'(ADDR_COEF_BASE) + 5'(TAPS));
    assign coef_idx   = address - ADDR_COEF_BASE;
    assign wr_push    = data_write && (address == ADDR_OUT);
    assign wr_status  = data_write && (address == ADDR_STATUS);
    assign wr_ctrl    = data_write && (address == ADDR_CTRL);
    assign wr_coef    = data_write && is_coef && !busy;
    assign clr        = wr_ctrl && data_in[CTRL_CLR];
    assign push_ok    = wr_push && !busy && !clr;
    assign new_sample = src_q ? ui_in : data_in;
    assign uo_out     = out_q;

    // Route the tap the MAC is currently working on.
    always_comb begin
        cur_sample = 8'h00;
        cur_coef   = 8'h00;
        for (int k = 0; k < TAPS; k++) begin
            if (tap_sel == IDX_W'(k)) begin
                cur_sample = samples_q[k];
                cur_coef   = coef_q[k];
            end
        end
    end

    tqvp_fir_mac_unit #(
        .TAPS  (TAPS),
        .ACC_W (ACC_W),
        .IDX_W (IDX_W)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (push_ok),
        .abort   (clr),
        .shift   (shift_q),
        .sample  (cur_sample),
        .coef    (cur_coef),
        .tap_sel (tap_sel),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    // Delay line and fill count; CLR empties both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) samples_q[k] <= 8'h00;
            count_q <= 4'h0;
        end else if (clr) begin
            for (int k = 0; k < TAPS; k++) samples_q[k] <= 8'h00;
            count_q <= 4'h0;
        end else if (push_ok) begin
            for (int k = TAPS - 1; k > 0; k--) samples_q[k] <= samples_q[k-1];
            samples_q[0] <= new_sample;
            if (count_q < 4'(TAPS)) count_q <= count_q + 4'd1;
        end
    end

    // Coefficients are frozen while a computation is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) coef_q[k] <= 8'h00;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (wr_coef && coef_idx == 4'(k)) coef_q[k] <= data_in;
            end
        end
    end

    // CTRL fields; a CLR write leaves SRC and SHIFT as they were.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= 1'b0;
            shift_q <= 3'd0;
        end else if (wr_ctrl && !clr) begin
            src_q   <= data_in[CTRL_SRC];
            shift_q <= data_in[CTRL_SHIFT_HI:CTRL_SHIFT_LO];
        end
    end

    // Result register and VALID flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= 8'h00;
            valid_q <= 1'b0;
        end else if (clr) begin
            out_q   <= 8'h00;
            valid_q <= 1'b0;
        end else if (push_ok) begin
            valid_q <= 1'b0;
        end else if (done) begin
            out_q   <= result;
            valid_q <= 1'b1;
        end
    end

    // Sticky overrun: a push that arrives while busy is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else if (wr_push && busy) begin
            ovr_q <= 1'b1;
        end else if (wr_status && data_in[STATUS_OVR_CLR]) begin
            ovr_q <= 1'b0;
        end
    end

    // Read mux.
    always_comb begin
        data_out = 8'h00;
        unique case (1'b1)
            address == ADDR_OUT:    data_out = out_q;
            address == ADDR_STATUS: data_out = {5'b0, ovr_q, valid_q, busy};
            address == ADDR_CTRL:   data_out = {4'b0, shift_q, src_q};
            address == ADDR_COUNT:  data_out = {4'b0, count_q};
            is_coef: begin
                for (int k = 0; k < TAPS; k++) begin
                    if (coef_idx == 4'(k)) data_out = coef_q[k];
                end
            end
            default: data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_tqvp_fir_mac_filter.sv
// Bench for the TinyQV FIR MAC filter.
// Directed cases plus random bus traffic against a dot-product model.
module tb_tqvp_fir_mac_filter;

    localparam int TAPS = 8;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int n_checks = 0;
    int n_errors = 0;

    tqvp_fir_mac_filter #(.TAPS(TAPS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: state as the register map describes it.
    int m_s [TAPS];
    int m_c [TAPS];
    int m_out, m_count, m_shift, m_dot, m_rem;
    bit m_src, m_ovr, m_valid, m_busy_now;
    int m_v;

    function automatic int m_read(input int a);
        if (a == 0) return m_out;
        if (a == 1) return (int'(m_ovr) << 2) | (int'(m_valid) << 1) |
                           int'(m_rem > 0);
        if (a == 2) return (m_shift << 1) | int'(m_src);
        if (a == 3) return m_count;
        if (a >= 4 && a < 4 + TAPS) return m_c[a-4];
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                m_s[k] = 0;
                m_c[k] = 0;
            end
            m_out = 0; m_count = 0; m_shift = 0; m_dot = 0; m_rem = 0;
            m_src = 0; m_ovr = 0; m_valid = 0;
        end else begin
            m_busy_now = (m_rem > 0);
            if (data_write && address == 4'h2 && data_in[7]) begin
                for (int k = 0; k < TAPS; k++) m_s[k] = 0;
                m_count = 0; m_out = 0; m_valid = 0; m_rem = 0;
            end else begin
                if (m_rem > 0) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_v = m_dot >> m_shift;
                        m_out = (m_v > 255) ? 255 : m_v;
                        m_valid = 1;
                    end
                end
                if (data_write) begin
                    if (address == 4'h0) begin
                        if (m_busy_now) m_ovr = 1;
                        else begin
                            for (int k = TAPS - 1; k > 0; k--) m_s[k] = m_s[k-1];
                            m_s[0] = m_src ? int'(ui_in) : int'(data_in);
                            if (m_count < TAPS) m_count++;
                            m_valid = 0;
                            m_dot = 0;
                            for (int k = 0; k < TAPS; k++)
                                m_dot += m_s[k] * m_c[k];
                            m_rem = TAPS + 1;
                        end
                    end else if (address == 4'h1) begin
                        if (data_in[2]) m_ovr = 0;
                    end else if (address == 4'h2) begin
                        m_src = data_in[0];
                        m_shift = int'(data_in[3:1]);
                    end else if (int'(address) >= 4 &&
                                 int'(address) < 4 + TAPS) begin
                        if (!m_busy_now) m_c[int'(address) - 4] = int'(data_in);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    // Every cycle out of reset: uo_out and read data against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("uo_out", int'(uo_out), m_out);
            chk($sformatf("data_out[%0d]", address), int'(data_out),
                m_read(int'(address)));
        end
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        address = a;
        data_in = d;
        data_write = 1'b1;
        @(posedge clk); #1;
        data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output int v);
        address = a;
        #1;
        v = int'(data_out);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            address = 4'h1;
            #1;
            if (!data_out[0]) return;
            @(posedge clk); #1;
        end
        n_checks++;
        n_errors++;
        $display("FAIL wait_idle: BUSY still 1 after 100 cycles");
    endtask

    task automatic push_check(input logic [7:0] d, input int exp,
                              input string name);
        int v;
        wr(4'h0, d);
        wait_idle();
        rd(4'h0, v);
        chk(name, v, exp);
    endtask

    int v;
    int n;
    int r;
    int exp_seq [4] = '{1, 3, 6, 10};
    logic [7:0] d;

    initial begin
        rst_n = 1'b0;
        data_write = 1'b0;
        address = 4'h0;
        data_in = 8'h00;
        ui_in = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        for (int a = 0; a < 16; a++) begin
            rd(4'(a), v);
            chk($sformatf("reset_rd[%0d]", a), v, 0);
        end
        chk("reset_uo_out", int'(uo_out), 0);

        for (int k = 0; k < 4; k++) wr(4'(4 + k), 8'd1);
        wr(4'h2, 8'h04);
        for (int i = 0; i < 4; i++) begin
            push_check(8'(4 * (i + 1)), exp_seq[i], $sformatf("avg_out%0d", i));
            rd(4'h1, v);
            chk("avg_valid", v & 2, 2);
        end
        rd(4'h3, v);
        chk("avg_count", v, 4);

        for (int k = 1; k < 4; k++) wr(4'(4 + k), 8'd0);
        wr(4'h4, 8'd255);
        wr(4'h2, 8'h00);
        push_check(8'd255, 255, "sat_shift0");
        wr(4'h2, 8'h0e);
        push_check(8'd255, 255, "sat_shift7");
        wr(4'h4, 8'd1);
        wr(4'h2, 8'h06);
        push_check(8'd200, 25, "shift3_200");

        wr(4'h2, 8'h00);
        wr(4'h0, 8'd50);
        n = 0;
        address = 4'h1;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (!data_out[0]) break;
            n++;
            @(posedge clk); #1;
        end
        chk("busy_cycles", n, TAPS + 1);
        chk("latency_out", int'(uo_out), 50);

        wr(4'h2, 8'h80);
        wr(4'h0, 8'd50);
        wr(4'h0, 8'd99);
        wait_idle();
        rd(4'h0, v);
        chk("ovr_result", v, 50);
        rd(4'h3, v);
        chk("ovr_count", v, 1);
        rd(4'h1, v);
        chk("ovr_set", v & 4, 4);
        wr(4'h1, 8'h04);
        rd(4'h1, v);
        chk("ovr_clear", v & 4, 0);

        wr(4'h2, 8'h01);
        ui_in = 8'h40;
        push_check(8'haa, 8'h40, "src_ui_in");

        wr(4'h0, 8'h01);
        idle(2);
        wr(4'h2, 8'h81);
        rd(4'h1, v);
        chk("clr_busy", v & 1, 0);
        chk("clr_uo_out", int'(uo_out), 0);
        rd(4'h3, v);
        chk("clr_count", v, 0);
        rd(4'h4, v);
        chk("clr_coef_kept", v, 1);
        rd(4'h2, v);
        chk("clr_ctrl_kept", v, 8'h01);
        wr(4'h0, 8'h05);
        wr(4'h5, 8'h77);
        wait_idle();
        rd(4'h5, v);
        chk("coef_busy_ignored", v, 0);

        wr(4'h0, 8'h03);
        idle(2);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_uo_out", int'(uo_out), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);
        rd(4'h1, v);
        chk("rst_mid_status", v, 0);
        rd(4'h4, v);
        chk("rst_mid_coef", v, 0);

        for (int i = 0; i < 3000; i++) begin
            ui_in = 8'($urandom);
            r = $urandom_range(0, 99);
            d = 8'($urandom);
            if (r < 30) begin
                wr(4'h0, d);
            end else if (r < 40) begin
                wr(4'($urandom_range(4, 4 + TAPS - 1)), d);
            end else if (r < 48) begin
                if ($urandom_range(0, 7) != 0) d[7] = 1'b0;
                wr(4'h2, d);
            end else if (r < 52) begin
                wr(4'h1, d);
            end else begin
                address = 4'($urandom);
                idle(1);
            end
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
